arm7_mem_responder: RTL and testbench
=====================================

Name: arm7_mem_responder

Overview:
Memory-side responder for the core's ARM7-style memory interface. It samples nMREQ/seq/nRW/mas/A from the core, inserts programmable nonsequential/sequential wait states through nWAIT, returns lane-replicated read data on DIN, and commits byte/halfword/word writes from DOUT into an internal word array. One instance serves one address region. The top level ANDs together the nWAIT outputs of all instances and ORs together their DIN outputs.

Parameters:
REGION, 8'h08, value A[31:24] must match for this instance to respond
ADDR_W, 10, log2 of array depth in 32-bit words; the window mirrors modulo 2^(ADDR_W+2) bytes
SEQ_BOUND_LOG2, 17, a sequential access whose A[SEQ_BOUND_LOG2-1:0]==0 is forced nonsequential

Ports:
mclk  in  1  clock, rising edge
nReset  in  1  asynchronous active-low reset
nMREQ  in  1  0 = memory request this cycle
seq  in  1  1 = core claims sequential to the previous access
nRW  in  1  0 = read, 1 = write
mas  in  2  00 byte, 01 halfword, 10 word, 11 treated as word
A  in  32  byte address
DOUT  in  32  write data from core, lane-replicated by the core
n_wait_cfg  in  4  wait states for nonsequential accesses
s_wait_cfg  in  4  wait states for sequential accesses
DIN  out  32  read data to core
nWAIT  out  1  0 = stall the core
seq_err  out  1  one-cycle pulse: seq=1 but address not consecutive

Behaviour:
- Reset (asynchronous, nReset=0):
  - state=IDLE, nWAIT=1, DIN=0, seq_err=0, prev_valid=0.
  - Array contents are not reset.
  - A write in flight is dropped and never committed.
- States: IDLE, WAIT, DATA. All outputs are registered except the DIN read mux.
- Capture: at a rising edge with nMREQ=0, A[31:24]==REGION, nWAIT=1 and state in {IDLE, DATA}:
  - Latch A, mas, nRW, DOUT-lane info.
  - Latch W = seq_eff ? s_wait_cfg : n_wait_cfg. Config changes after capture have no effect on that access.
  - If W>0: state goes to WAIT with cnt=W-1 and nWAIT=0. Otherwise state goes to DATA.
- WAIT: nWAIT stays 0. cnt decrements each edge. When cnt==0, the next state is DATA with nWAIT=1.
- DATA: nWAIT=1 and DIN is valid for the captured read.
  - At the edge ending DATA, a write commits.
  - The same edge may capture the next request (back-to-back, zero dead cycles). Otherwise state returns to IDLE with DIN=0.
- Net latency: exactly W stall cycles per access.
- seq_eff = seq and prev_valid and (A == prev_addr + size) and A[SEQ_BOUND_LOG2-1:0] != 0.
  - If seq=1 and the address is not consecutive (including prev_valid=0): the access uses N waits and seq_err pulses for one cycle after capture.
  - A boundary crossing alone forces N waits but does not raise seq_err.
  - prev_addr and size update on every captured access.
- Unselected region or nMREQ=1: no capture. nWAIT stays 1 and DIN=0.
- Index = A[ADDR_W+1:2], so addresses alias (mirror).
- Reads:
  - Word: the aligned word; A[1:0] is ignored and the core rotates.
  - Halfword: the selected half, replicated {h,h}.
  - Byte: the selected byte, replicated {b,b,b,b}.
  - DIN is read combinationally from the array at the latched index, so a read captured on the edge that commits a write sees the new data.
- Writes take the addressed lanes of DOUT:
  - Byte: lane A[1:0].
  - Halfword: lane A[1].
  - Word: all four lanes.
- nReset asserted mid-WAIT: nWAIT=1 immediately and the array is unchanged.

Test Plan:
1. Reset; n_wait_cfg=3; nonsequential word write of 0xDEADBEEF to 0x0800_0010 -> nWAIT=0 for 3 cycles, then 1; array[4]=0xDEADBEEF. Nonsequential read of the same address -> 3 stall cycles, then DIN=0xDEADBEEF in DATA.
2. n_wait_cfg=3, s_wait_cfg=1; word reads at 0x0800_0010 (seq=0), then 0x14 and 0x18 (seq=1), back-to-back -> stalls 3, 1, 1; seq_err stays 0; no idle cycles between DATA and the next capture.
3. Byte write at 0x0800_0013 with DOUT=0xABABABAB -> word read 0xABADBEEF; halfword read at 0x12 -> 0xABADABAD; byte read at 0x11 -> 0xBEBEBEBE.
4. Sequential word read 0x0801_FFFC, then 0x0802_0000 with seq=1 -> the second uses n_wait_cfg, seq_err=0. Then seq=1 to 0x0802_0040 -> n_wait_cfg and a one-cycle seq_err pulse.
5. Write with n_wait_cfg=5; drop nReset during the 2nd stall cycle -> nWAIT=1 and DIN=0 immediately; a later read of the target returns the old contents.
6. Request at 0x0300_0000 (REGION=8'h08) -> nWAIT stays 1, DIN=0, no array change, seq_err=0.

Source files
------------

// File: rtl/arm7_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : arm7_mem_responder
//  Purpose  : Memory-side responder for an ARM7-style memory bus. Serves one
//             address region (A[31:24] == REGION), inserts programmable
//             nonsequential / sequential wait states through nWAIT, returns
//             lane-replicated read data on DIN and commits byte / halfword /
//             word writes into an internal mirrored word array.
//  Ports    : mclk        - clock, rising edge
//             nReset      - asynchronous active-low reset
//             nMREQ       - 0 = memory request this cycle
//             seq         - core claims the access is sequential
//             nRW         - 0 = read, 1 = write
//             mas         - 00 byte, 01 halfword, 10/11 word
//             A           - byte address
//             DOUT        - lane-replicated write data from the core
//             n_wait_cfg  - wait states for nonsequential accesses
//             s_wait_cfg  - wait states for sequential accesses
//             DIN         - read data to core (0 when not in a read DATA phase)
//             nWAIT       - 0 = stall the core
//             seq_err     - one-cycle pulse: seq=1 on a non-consecutive address
//  Revision : 1.0 - initial release
// ============================================================================
module arm7_mem_responder #(
    parameter logic [7:0] REGION         = 8'h08,
    parameter int         ADDR_W         = 10,
    parameter int         SEQ_BOUND_LOG2 = 17
) (
    input  logic        mclk,
    input  logic        nReset,
    input  logic        nMREQ,
    input  logic        seq,
    input  logic        nRW,
    input  logic [1:0]  mas,
    input  logic [31:0] A,
    input  logic [31:0] DOUT,
    input  logic [3:0]  n_wait_cfg,
    input  logic [3:0]  s_wait_cfg,
    output logic [31:0] DIN,
    output logic        nWAIT,
    output logic        seq_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        nwait_q, nwait_d;
    logic        seq_err_q, seq_err_d;
    logic [31:0] addr_q;
    logic [1:0]  mas_q;
    logic        nrw_q;
    logic [31:0] dout_q;
    logic        prev_valid_q;

    logic [31:0] mem_q [0:(2**ADDR_W)-1];

    logic              w_capture;
    logic [31:0]       w_prev_size;
    logic              w_consec;
    logic              w_seq_eff;
    logic [3:0]        w_wait;
    logic [ADDR_W-1:0] w_idx;
    logic [31:0]       w_word;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [31:0]       w_rdata;
    logic              w_commit;

    // A new request is only accepted when the bus is not stalled and the
    // previous access is finished (or in its final DATA cycle).
    assign w_capture = !nMREQ && (A[31:24] == REGION) && nwait_q &&
                       ((state_q == S_IDLE) || (state_q == S_DATA));

    // The latched address/size of the last captured access double as the
    // reference for the sequential-address check.
    always_comb begin
        case (mas_q)
            2'b00:   w_prev_size = 32'd1;
            2'b01:   w_prev_size = 32'd2;
            default: w_prev_size = 32'd4;
        endcase
    end

    assign w_consec  = prev_valid_q && (A == addr_q + w_prev_size);
    // A boundary crossing demotes the access to nonsequential but is not an error.
    assign w_seq_eff = seq && w_consec && (A[SEQ_BOUND_LOG2-1:0] != '0);
    assign w_wait    = w_seq_eff ? s_wait_cfg : n_wait_cfg;

    // ---------------------------------------------------------------- state
    always_ff @(posedge mclk or negedge nReset) begin
        if (!nReset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            nwait_q      <= 1'b1;
            seq_err_q    <= 1'b0;
            addr_q       <= 32'd0;
            mas_q        <= 2'b00;
            nrw_q        <= 1'b0;
            dout_q       <= 32'd0;
            prev_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            nwait_q   <= nwait_d;
            seq_err_q <= seq_err_d;
            if (w_capture) begin
                addr_q       <= A;
                mas_q        <= mas;
                nrw_q        <= nRW;
                dout_q       <= DOUT;
                prev_valid_q <= 1'b1;
            end
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_DATA: begin
                if (w_capture) begin
                    if (w_wait != 4'd0) begin
                        state_d = S_WAIT;
                        cnt_d   = w_wait - 4'd1;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        nwait_d   = (state_d != S_WAIT);
        seq_err_d = w_capture && seq && !w_consec;
        DIN       = ((state_q == S_DATA) && !nrw_q) ? w_rdata : 32'd0;
    end

    assign nWAIT   = nwait_q;
    assign seq_err = seq_err_q;

    // --------------------------------------------------------------- array
    assign w_idx  = addr_q[ADDR_W+1:2];
    assign w_word = mem_q[w_idx];

    always_comb begin
        case (mas_q)
            2'b00:   w_be = 4'b0001 << addr_q[1:0];
            2'b01:   w_be = addr_q[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    always_comb begin
        w_wdata = w_word;
        for (int i = 0; i < 4; i++) begin
            if (w_be[i]) begin
                w_wdata[8*i +: 8] = dout_q[8*i +: 8];
            end
        end
    end

    always_comb begin
        case (mas_q)
            2'b00:   w_rdata = {4{w_word[{addr_q[1:0], 3'b000} +: 8]}};
            2'b01:   w_rdata = addr_q[1] ? {2{w_word[31:16]}} : {2{w_word[15:0]}};
            default: w_rdata = w_word;
        endcase
    end

    // Reset forces state_q out of DATA asynchronously, so an in-flight write
    // can never reach this enable.
    assign w_commit = (state_q == S_DATA) && nrw_q;

    always_ff @(posedge mclk) begin
        if (w_commit) begin
            mem_q[w_idx] <= w_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_arm7_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_arm7_mem_responder
//  Purpose  : Directed self-checking bench for arm7_mem_responder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_arm7_mem_responder;

    logic        mclk = 1'b0;
    logic        nReset;
    logic        nMREQ;
    logic        seq;
    logic        nRW;
    logic [1:0]  mas;
    logic [31:0] A;
    logic [31:0] DOUT;
    logic [3:0]  n_wait_cfg;
    logic [3:0]  s_wait_cfg;
    logic [31:0] DIN;
    logic        nWAIT;
    logic        seq_err;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    arm7_mem_responder #(
        .REGION        (8'h08),
        .ADDR_W        (10),
        .SEQ_BOUND_LOG2(17)
    ) dut (
        .mclk      (mclk),
        .nReset    (nReset),
        .nMREQ     (nMREQ),
        .seq       (seq),
        .nRW       (nRW),
        .mas       (mas),
        .A         (A),
        .DOUT      (DOUT),
        .n_wait_cfg(n_wait_cfg),
        .s_wait_cfg(s_wait_cfg),
        .DIN       (DIN),
        .nWAIT     (nWAIT),
        .seq_err   (seq_err)
    );

    always #5 mclk = ~mclk;
    always @(posedge mclk) cyc++;

    // Called on a negedge. Presents one request, releases nMREQ after the
    // capture edge, then counts stall cycles until the DATA cycle.
    task automatic access(input logic [31:0] a, input logic wr, input logic [1:0] m,
                          input logic s, input logic [31:0] d,
                          output int stalls, output logic [31:0] din, output int serr);
        bit done;
        done   = 1'b0;
        stalls = 0;
        serr   = 0;
        din    = 32'd0;
        nMREQ  = 1'b0; A = a; nRW = wr; mas = m; seq = s; DOUT = d;
        @(posedge mclk);
        #1;
        nMREQ = 1'b1; seq = 1'b0; nRW = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge mclk);
            if (seq_err) serr++;
            if (nWAIT) begin
                done = 1'b1;
                din  = DIN;
            end else begin
                stalls++;
            end
        end
        checks++;
        if (!done) begin
            fails++;
            $display("FAIL access_timeout addr=%h: nWAIT never returned to 1", a);
        end
    endtask

    task automatic test_reset();
        nReset = 1'b0; nMREQ = 1'b1; seq = 1'b0; nRW = 1'b0; mas = 2'b10;
        A = 32'd0; DOUT = 32'd0; n_wait_cfg = 4'd3; s_wait_cfg = 4'd1;
        repeat (3) @(negedge mclk);
        checks++; if (nWAIT !== 1'b1)    begin fails++; $display("FAIL reset_nwait got=%b exp=1", nWAIT); end
        checks++; if (DIN !== 32'd0)     begin fails++; $display("FAIL reset_din got=%h exp=0", DIN); end
        checks++; if (seq_err !== 1'b0)  begin fails++; $display("FAIL reset_seq_err got=%b exp=0", seq_err); end
        nReset = 1'b1;
        @(negedge mclk);
        checks++; if (nWAIT !== 1'b1)    begin fails++; $display("FAIL idle_nwait got=%b exp=1", nWAIT); end
    endtask

    task automatic test_write_read();
        int st, se; logic [31:0] dn;
        n_wait_cfg = 4'd3; s_wait_cfg = 4'd1;
        access(32'h0800_0010, 1'b1, 2'b10, 1'b0, 32'hDEAD_BEEF, st, dn, se);
        checks++; if (st !== 3)          begin fails++; $display("FAIL wr_stalls got=%0d exp=3", st); end
        checks++; if (dn !== 32'd0)      begin fails++; $display("FAIL wr_din got=%h exp=0", dn); end
        @(negedge mclk);
        access(32'h0800_0010, 1'b0, 2'b10, 1'b0, 32'd0, st, dn, se);
        checks++; if (st !== 3)          begin fails++; $display("FAIL rd_stalls got=%0d exp=3", st); end
        checks++; if (dn !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rd_data got=%h exp=deadbeef", dn); end
        @(negedge mclk);
        checks++; if (DIN !== 32'd0)     begin fails++; $display("FAIL idle_din got=%h exp=0", DIN); end
    endtask

    task automatic test_back_to_back();
        int st, se, start; logic [31:0] dn;
        n_wait_cfg = 4'd3; s_wait_cfg = 4'd1;
        start = cyc;
        access(32'h0800_0010, 1'b0, 2'b10, 1'b0, 32'd0, st, dn, se);
        checks++; if (st !== 3)          begin fails++; $display("FAIL b2b0_stalls got=%0d exp=3", st); end
        checks++; if (dn !== 32'hDEAD_BEEF) begin fails++; $display("FAIL b2b0_data got=%h exp=deadbeef", dn); end
        access(32'h0800_0014, 1'b0, 2'b10, 1'b1, 32'd0, st, dn, se);
        checks++; if (st !== 1)          begin fails++; $display("FAIL b2b1_stalls got=%0d exp=1", st); end
        checks++; if (se !== 0)          begin fails++; $display("FAIL b2b1_seq_err got=%0d exp=0", se); end
        access(32'h0800_0018, 1'b0, 2'b10, 1'b1, 32'd0, st, dn, se);
        checks++; if (st !== 1)          begin fails++; $display("FAIL b2b2_stalls got=%0d exp=1", st); end
        checks++; if (se !== 0)          begin fails++; $display("FAIL b2b2_seq_err got=%0d exp=0", se); end
        checks++; if (cyc - start !== 8) begin fails++; $display("FAIL b2b_cycles got=%0d exp=8", cyc - start); end
        @(negedge mclk);
    endtask

    task automatic test_lanes();
        int st, se; logic [31:0] dn;
        access(32'h0800_0013, 1'b1, 2'b00, 1'b0, 32'hABAB_ABAB, st, dn, se);
        @(negedge mclk);
        access(32'h0800_0010, 1'b0, 2'b10, 1'b0, 32'd0, st, dn, se);
        checks++; if (dn !== 32'hABAD_BEEF) begin fails++; $display("FAIL lane_word got=%h exp=abadbeef", dn); end
        access(32'h0800_0012, 1'b0, 2'b01, 1'b0, 32'd0, st, dn, se);
        checks++; if (dn !== 32'hABAD_ABAD) begin fails++; $display("FAIL lane_half got=%h exp=abadabad", dn); end
        access(32'h0800_0011, 1'b0, 2'b00, 1'b0, 32'd0, st, dn, se);
        checks++; if (dn !== 32'hBEBE_BEBE) begin fails++; $display("FAIL lane_byte got=%h exp=bebebebe", dn); end
        // Read captured on the same edge that commits the preceding write.
        access(32'h0800_0020, 1'b1, 2'b10, 1'b0, 32'h1234_5678, st, dn, se);
        access(32'h0800_0020, 1'b0, 2'b10, 1'b0, 32'd0, st, dn, se);
        checks++; if (dn !== 32'h1234_5678) begin fails++; $display("FAIL wr_then_rd got=%h exp=12345678", dn); end
        // Mirror: 0x0800_1020 aliases index 8.
        access(32'h0800_1020, 1'b0, 2'b10, 1'b0, 32'd0, st, dn, se);
        checks++; if (dn !== 32'h1234_5678) begin fails++; $display("FAIL mirror got=%h exp=12345678", dn); end
        @(negedge mclk);
    endtask

    task automatic test_seq_boundary();
        int st, se; logic [31:0] dn;
        n_wait_cfg = 4'd3; s_wait_cfg = 4'd1;
        access(32'h0801_FFFC, 1'b0, 2'b10, 1'b0, 32'd0, st, dn, se);
        checks++; if (st !== 3)          begin fails++; $display("FAIL bnd0_stalls got=%0d exp=3", st); end
        access(32'h0802_0000, 1'b0, 2'b10, 1'b1, 32'd0, st, dn, se);
        checks++; if (st !== 3)          begin fails++; $display("FAIL bnd1_stalls got=%0d exp=3", st); end
        checks++; if (se !== 0)          begin fails++; $display("FAIL bnd1_seq_err got=%0d exp=0", se); end
        access(32'h0802_0040, 1'b0, 2'b10, 1'b1, 32'd0, st, dn, se);
        checks++; if (st !== 3)          begin fails++; $display("FAIL nonc_stalls got=%0d exp=3", st); end
        checks++; if (se !== 1)          begin fails++; $display("FAIL nonc_seq_err_cycles got=%0d exp=1", se); end
        @(negedge mclk);
    endtask

    task automatic test_reset_midwait();
        int st, se; logic [31:0] dn;
        n_wait_cfg = 4'd5;
        nMREQ = 1'b0; A = 32'h0800_0010; nRW = 1'b1; mas = 2'b10; seq = 1'b0; DOUT = 32'h1122_3344;
        @(posedge mclk);
        #1;
        nMREQ = 1'b1; nRW = 1'b0;
        @(negedge mclk);
        checks++; if (nWAIT !== 1'b0)    begin fails++; $display("FAIL mw_stall1 got=%b exp=0", nWAIT); end
        @(negedge mclk);
        nReset = 1'b0;
        #1;
        checks++; if (nWAIT !== 1'b1)    begin fails++; $display("FAIL mw_nwait got=%b exp=1", nWAIT); end
        checks++; if (DIN !== 32'd0)     begin fails++; $display("FAIL mw_din got=%h exp=0", DIN); end
        repeat (2) @(negedge mclk);
        nReset = 1'b1;
        @(negedge mclk);
        access(32'h0800_0010, 1'b0, 2'b10, 1'b0, 32'd0, st, dn, se);
        checks++; if (st !== 5)          begin fails++; $display("FAIL mw_rd_stalls got=%0d exp=5", st); end
        checks++; if (dn !== 32'hABAD_BEEF) begin fails++; $display("FAIL mw_rd_data got=%h exp=abadbeef", dn); end
        @(negedge mclk);
    endtask

    task automatic test_unselected();
        int st, se; logic [31:0] dn;
        n_wait_cfg = 4'd3;
        nMREQ = 1'b0; A = 32'h0300_0010; nRW = 1'b1; mas = 2'b10; seq = 1'b0; DOUT = 32'h5555_5555;
        for (int i = 0; i < 3; i++) begin
            @(negedge mclk);
            checks++; if (nWAIT !== 1'b1)   begin fails++; $display("FAIL unsel_nwait cyc%0d got=%b exp=1", i, nWAIT); end
            checks++; if (DIN !== 32'd0)    begin fails++; $display("FAIL unsel_din cyc%0d got=%h exp=0", i, DIN); end
            checks++; if (seq_err !== 1'b0) begin fails++; $display("FAIL unsel_seq_err cyc%0d got=%b exp=0", i, seq_err); end
        end
        nMREQ = 1'b1; nRW = 1'b0;
        @(negedge mclk);
        access(32'h0800_0010, 1'b0, 2'b10, 1'b0, 32'd0, st, dn, se);
        checks++; if (dn !== 32'hABAD_BEEF) begin fails++; $display("FAIL unsel_array got=%h exp=abadbeef", dn); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_lanes();
        test_seq_boundary();
        test_reset_midwait();
        test_unselected();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
